// File: rtl/inpref_pkg.sv
// Shared types and helpers for the input prefetcher.
package inpref_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // mode_sel encoding: bit1 selects cutting, bit0 selects stride 1
    localparam logic [1:0] MODE_FIRST_S2 = 2'b00;
    localparam logic [1:0] MODE_FIRST_S1 = 2'b01;
    localparam logic [1:0] MODE_CUT_S2   = 2'b10;
    localparam logic [1:0] MODE_CUT_S1   = 2'b11;

    function automatic logic [1:0] stride_of(input logic [1:0] mode);
        logic [1:0] s;
        case (mode)
            MODE_FIRST_S1, MODE_CUT_S1: s = 2'd1;
            MODE_FIRST_S2, MODE_CUT_S2: s = 2'd2;
            default:                    s = 2'd2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/inpref_ring.sv
// Circular word buffer with occupancy count and a LANES-wide window read mux.
module inpref_ring
    import inpref_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      fsm_rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    input  logic [1:0]                stride,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      wr_ready,
    output logic [LANES*DATA_W-1:0]   window
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Full check ignores a same-cycle pop on purpose
    assign wr_ready = (count_q < CW'(DEPTH));
    assign count    = count_q;

    // Next read pointer and occupancy; a push lands after a flush
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(stride);
            count_d  = count_q - CW'(stride);
        end
        if (push) begin
            count_d = count_d + CW'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage, cleared on reset so the idle window reads as zero
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Window mux: lane 0 is the oldest word at rd_ptr
    always_comb begin
        window = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            window[i*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

endmodule

// File: rtl/input_prefetcher.sv
// Input prefetcher: buffers pushed activations and streams sliding windows
// into the systolic array at stride 1 or 2, flushing or keeping the previous
// frame's tail at frame start. Optional stats: define INPREF_STATS_EN.
module input_prefetcher
    import inpref_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    fsm_rst_n,
    input  logic                    in_en,
    input  logic [1:0]              mode_sel,
    input  logic                    en_cutting,
    input  logic                    wr_valid,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    output logic                    rd_valid,
    output logic [LANES*DATA_W-1:0] rd_data,
    input  logic                    rd_ready,
    output logic [1:0]              state_o
`ifdef INPREF_STATS_EN
    ,
    output logic [15:0]             underrun_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        state_q;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] count;
    logic [1:0]    stride;
    logic          start, flush, push, pop, have_window;

    // mode_q[1] holds the effective cutting flag (mode_sel[1] qualified by en_cutting)
    assign start       = (state_q == IDLE) && in_en;
    assign mode_d      = start ? {mode_sel[1] & en_cutting, mode_sel[0]} : mode_q;
    assign flush       = start && !mode_d[1];
    assign have_window = (count >= CW'(LANES));
    assign rd_valid    = (state_q == STREAM) && in_en && have_window;
    assign push        = wr_valid && wr_ready;
    assign pop         = rd_valid && rd_ready;
    assign stride      = stride_of(mode_q);
    assign state_o     = state_q;

    inpref_ring #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk       (clk),
        .fsm_rst_n (fsm_rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .stride    (stride),
        .count     (count),
        .wr_ready  (wr_ready),
        .window    (rd_data)
    );

    // Frame FSM and mode latch; in_en low returns to IDLE from any state
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_FIRST_S2;
        end else begin
            mode_q <= mode_d;
            if (!in_en) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:    state_q <= FILL;
                    FILL:    if (have_window) state_q <= STREAM;
                    STREAM:  state_q <= STREAM;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef INPREF_STATS_EN
    logic [15:0] underrun_cnt_q;
    logic        underrun;

    assign underrun     = (state_q == STREAM) && in_en && !have_window;
    assign underrun_cnt = underrun_cnt_q;

    // Saturating count of starved streaming cycles, cleared at frame start
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            underrun_cnt_q <= '0;
        end else if (start) begin
            underrun_cnt_q <= '0;
        end else if (underrun && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_prefetcher.sv
// Self-checking bench for input_prefetcher: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_input_prefetcher;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        fsm_rst_n = 1'b0;
    logic        in_en = 1'b0;
    logic [1:0]  mode_sel = 2'b00;
    logic        en_cutting = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        rd_ready = 1'b0;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  state_o;
`ifdef INPREF_STATS_EN
    logic [15:0] underrun_cnt;
`endif

    always #5 clk = ~clk;

    input_prefetcher #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .fsm_rst_n    (fsm_rst_n),
        .in_en        (in_en),
        .mode_sel     (mode_sel),
        .en_cutting   (en_cutting),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .state_o      (state_o)
`ifdef INPREF_STATS_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Reference model: buffer contents as a FIFO queue of words
    logic [7:0] mq[$];
    int         mst;      // 0 idle, 1 fill, 2 stream
    logic [1:0] mmode;    // {effective cutting, stride-1 flag}
    int         mund;

    // Outputs sampled mid-cycle by the last call to cyc
    logic        s_valid, s_wr;
    logic [31:0] s_data;
    logic [1:0]  s_state;

    task automatic model_reset();
        mq.delete();
        mst   = 0;
        mmode = 2'b00;
        mund  = 0;
    endtask

    function automatic logic [31:0] exp_window();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) w[i*8 +: 8] = mq[i];
        return w;
    endfunction

    task automatic model_step(input bit en, input bit [1:0] ms, input bit ec, input bit wv,
                              input bit [7:0] wd, input bit rr, input bit ev, input bit ew);
        int sz;
        int s;
        bit start;
        sz    = mq.size();
        s     = mmode[0] ? 1 : 2;
        start = (mst == 0) && en;
        if (start) mund = 0;
        else if (mst == 2 && en && sz < LANES && mund < 65535) mund++;
        if (ev && rr) for (int k = 0; k < s; k++) void'(mq.pop_front());
        if (start && !(ms[1] && ec)) mq.delete();
        if (wv && ew) mq.push_back(wd);
        if (!en) mst = 0;
        else if (mst == 0) begin
            mst   = 1;
            mmode = {ms[1] & ec, ms[0]};
        end else if (mst == 1 && sz >= LANES) mst = 2;
    endtask

    // One clock cycle: drive, sample and check mid-cycle, then advance the model
    task automatic cyc(input bit en, input bit [1:0] ms, input bit ec, input bit wv,
                       input bit [7:0] wd, input bit rr);
        bit ev, ew;
        in_en = en; mode_sel = ms; en_cutting = ec;
        wr_valid = wv; wr_data = wd; rd_ready = rr;
        #4;
        ev = (mst == 2) && en && (mq.size() >= LANES);
        ew = (mq.size() < DEPTH);
        s_valid = rd_valid; s_wr = wr_ready; s_data = rd_data; s_state = state_o;
        check("m_state", state_o, mst);
        check("m_rd_valid", rd_valid, ev);
        check("m_wr_ready", wr_ready, ew);
        if (ev) check("m_rd_data", rd_data, exp_window());
`ifdef INPREF_STATS_EN
        check("m_underrun_cnt", underrun_cnt, mund);
`endif
        @(posedge clk);
        #1;
        model_step(en, ms, ec, wv, wd, rr, ev, ew);
    endtask

    task automatic do_reset();
        fsm_rst_n = 1'b0;
        in_en = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        check("rst_state", state_o, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_data", rd_data, 0);
`ifdef INPREF_STATS_EN
        check("rst_underrun_cnt", underrun_cnt, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        fsm_rst_n = 1'b1;
    endtask

    typedef struct {
        bit        en;
        bit [1:0]  ms;
        bit        ec;
        bit        wv;
        bit [7:0]  wd;
        bit        rr;
        bit        ev;
        bit [31:0] ed;
        bit        ew;
        bit [1:0]  es;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit en, input bit [1:0] ms, input bit ec, input bit wv,
                       input bit [7:0] wd, input bit rr, input bit ev, input bit [31:0] ed,
                       input bit ew, input bit [1:0] es);
        vec_t v;
        v.en = en; v.ms = ms; v.ec = ec; v.wv = wv; v.wd = wd; v.rr = rr;
        v.ev = ev; v.ed = ed; v.ew = ew; v.es = es;
        tbl.push_back(v);
    endtask

    initial begin
        bit ren;

        // Frame A: first input, stride 1, push 0..7 -> five windows
        add(1, 2'b01, 0, 1, 8'd0, 1, 0, 0, 1, 0);
        add(1, 2'b01, 0, 1, 8'd1, 1, 0, 0, 1, 1);
        add(1, 2'b01, 0, 1, 8'd2, 1, 0, 0, 1, 1);
        add(1, 2'b01, 0, 1, 8'd3, 1, 0, 0, 1, 1);
        add(1, 2'b01, 0, 1, 8'd4, 1, 0, 0, 1, 1);
        add(1, 2'b01, 0, 1, 8'd5, 1, 1, 32'h03020100, 1, 2);
        add(1, 2'b01, 0, 1, 8'd6, 1, 1, 32'h04030201, 1, 2);
        add(1, 2'b01, 0, 1, 8'd7, 1, 1, 32'h05040302, 1, 2);
        add(1, 2'b01, 0, 0, 8'd0, 1, 1, 32'h06050403, 1, 2);
        add(1, 2'b01, 0, 0, 8'd0, 1, 1, 32'h07060504, 1, 2);
        add(1, 2'b01, 0, 0, 8'd0, 1, 0, 0, 1, 2);
        add(0, 2'b01, 0, 0, 8'd0, 1, 0, 0, 1, 2);
        // Frame B: first input, stride 2 -> three windows, residue 6,7
        add(1, 2'b00, 0, 1, 8'd0, 1, 0, 0, 1, 0);
        add(1, 2'b00, 0, 1, 8'd1, 1, 0, 0, 1, 1);
        add(1, 2'b00, 0, 1, 8'd2, 1, 0, 0, 1, 1);
        add(1, 2'b00, 0, 1, 8'd3, 1, 0, 0, 1, 1);
        add(1, 2'b00, 0, 1, 8'd4, 1, 0, 0, 1, 1);
        add(1, 2'b00, 0, 1, 8'd5, 1, 1, 32'h03020100, 1, 2);
        add(1, 2'b00, 0, 1, 8'd6, 1, 1, 32'h05040302, 1, 2);
        add(1, 2'b00, 0, 1, 8'd7, 1, 0, 0, 1, 2);
        add(1, 2'b00, 0, 0, 8'd0, 1, 1, 32'h07060504, 1, 2);
        add(1, 2'b00, 0, 0, 8'd0, 1, 0, 0, 1, 2);
        add(0, 2'b00, 0, 0, 8'd0, 1, 0, 0, 1, 2);
        // Frame C: cutting keeps 6,7 -> first window {6,7,8,9}
        add(1, 2'b11, 1, 1, 8'd8, 1, 0, 0, 1, 0);
        add(1, 2'b11, 1, 1, 8'd9, 1, 0, 0, 1, 1);
        add(1, 2'b11, 1, 0, 8'd0, 1, 0, 0, 1, 1);
        add(1, 2'b11, 1, 0, 8'd0, 1, 1, 32'h09080706, 1, 2);
        add(0, 2'b11, 1, 0, 8'd0, 1, 0, 0, 1, 2);
        // Frame D: cutting with en_cutting=0 flushes the residue
        add(1, 2'b11, 0, 1, 8'd8, 1, 0, 0, 1, 0);
        add(1, 2'b11, 0, 1, 8'd9, 1, 0, 0, 1, 1);
        add(1, 2'b11, 0, 0, 8'd0, 1, 0, 0, 1, 1);
        add(1, 2'b11, 0, 1, 8'd10, 1, 0, 0, 1, 1);
        add(1, 2'b11, 0, 1, 8'd11, 1, 0, 0, 1, 1);
        add(1, 2'b11, 0, 0, 8'd0, 1, 0, 0, 1, 1);
        add(1, 2'b11, 0, 0, 8'd0, 1, 1, 32'h0B0A0908, 1, 2);
        add(0, 2'b11, 0, 0, 8'd0, 0, 0, 0, 1, 2);

        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].en, tbl[i].ms, tbl[i].ec, tbl[i].wv, tbl[i].wd, tbl[i].rr);
            check($sformatf("tbl%0d_state", i), s_state, tbl[i].es);
            check($sformatf("tbl%0d_valid", i), s_valid, tbl[i].ev);
            check($sformatf("tbl%0d_wr_ready", i), s_wr, tbl[i].ew);
            if (tbl[i].ev) check($sformatf("tbl%0d_data", i), s_data, tbl[i].ed);
        end

        // Full buffer: 16 pushes with no pops, 17th dropped, one stride-2 pop
        for (int i = 0; i < 16; i++) cyc(1, 2'b00, 0, 1, 8'(8'h20 + i), 0);
        check("full_wr_ready", wr_ready, 0);
        cyc(1, 2'b00, 0, 1, 8'hFF, 0);
        check("full_hold_wr_ready", wr_ready, 0);
        cyc(1, 2'b00, 0, 0, 8'h00, 1);
        check("after_pop_wr_ready", wr_ready, 1);
        cyc(1, 2'b00, 0, 0, 8'h00, 0);
        check("after_pop_valid", s_valid, 1);
        check("after_pop_window", s_data, 32'h25242322);

        // Drain to six words, then reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1, 2'b00, 0, 0, 8'h00, 1);
        check("pre_reset_state", state_o, 2);
        do_reset();
        cyc(0, 2'b01, 0, 0, 8'h00, 1);
        cyc(0, 2'b01, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 2'b01, 0, (i < 4), 8'(8'h40 + i), 1);
            check($sformatf("post_reset_idle%0d", i), s_valid, 0);
        end
        cyc(1, 2'b01, 0, 0, 8'h00, 1);
        check("post_reset_first_valid", s_valid, 1);
        check("post_reset_first_window", s_data, 32'h43424140);
        cyc(0, 2'b01, 0, 0, 8'h00, 0);

`ifdef INPREF_STATS_EN
        // Enter STREAM with four words, pop once, then starve for five cycles
        for (int i = 0; i < 4; i++) cyc(1, 2'b01, 0, 1, 8'(8'h50 + i), 0);
        cyc(1, 2'b01, 0, 0, 8'h00, 0);
        cyc(1, 2'b01, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cyc(1, 2'b01, 0, 0, 8'h00, 0);
        check("stats_underrun5", underrun_cnt, 5);
        cyc(0, 2'b01, 0, 0, 8'h00, 0);
        check("stats_hold_idle", underrun_cnt, 5);
        cyc(1, 2'b01, 0, 0, 8'h00, 0);
        check("stats_cleared", underrun_cnt, 0);
        cyc(0, 2'b01, 0, 0, 8'h00, 0);
`endif

        // Randomized traffic against the model
        ren = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(19) == 0) ren = !ren;
            cyc(ren, 2'($urandom_range(3)), 1'($urandom_range(1)),
                ($urandom_range(3) != 0), 8'($urandom_range(255)),
                ($urandom_range(2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_prefetcher.md
# input_prefetcher

Input prefetcher feeding activation windows into the systolic array. It consumes the phase controller's stream-enable and input-prefetch mode controls (`in_en`, `mode_sel`, `en_cutting`), buffers words pushed from the output buffer, and emits LANES-wide sliding windows at stride 1 or 2. Depending on the mode, it either flushes at frame start ("first input") or keeps the previous frame's tail ("cutting").

## Interface
- DATA_W, 8, bits per activation word
- LANES, 4, words per emitted window; must be ≥2
- DEPTH, 16, buffer depth in words; must be a power of 2 and ≥2*LANES
- clk  input  1  clock, rising edge
- fsm_rst_n  input  1  reset, asynchronous, active-low
- in_en  input  1  frame enable from the phase controller; high for the whole frame
- mode_sel  input  2  bit1: 1=cutting, 0=first input; bit0: 1=stride 1, 0=stride 2
- en_cutting  input  1  qualifies cutting mode; when 0, cutting mode is treated as first input
- wr_valid  input  1  push request from the output buffer
- wr_data  input  DATA_W  push word
- wr_ready  output  1  buffer can accept a push
- rd_valid  output  1  window valid toward the array
- rd_data  output  LANES*DATA_W  window; lane 0 (oldest word) in LSBs
- rd_ready  input  1  array accepts the window
- state_o  output  2  current state, for debug

## Operation
- Circular storage of DEPTH words with wr_ptr, rd_ptr and count (0..DEPTH).
- Push: wr_valid&&wr_ready stores wr_data at wr_ptr, then wr_ptr+1 mod DEPTH and count+1. Pushes are accepted in every state, including IDLE.
- wr_ready = (count < DEPTH). It does not account for a same-cycle pop, so it is 0 when full even if a pop occurs.
- States:
  - IDLE=0: rd_valid=0.
  - FILL=1
  - STREAM=2
- IDLE→FILL when in_en=1 at a clock edge. At that edge, mode_sel and en_cutting are latched into mode_q. Changes to them mid-frame are ignored.
- Flush at frame start: applies when the latched mode_sel[1]=0 or en_cutting=0. The flush sets rd_ptr=wr_ptr and count=0. A push in the same cycle lands after the flush, so count=1.
- Cutting (mode_sel[1]=1 and en_cutting=1): buffer contents are retained across the frame boundary.
- FILL→STREAM when count ≥ LANES.
- Frame end: any state→IDLE on an edge where in_en=0. Buffer contents are retained.
- rd_valid = (state==STREAM) && in_en && (count ≥ LANES).
- rd_data lane i = storage[(rd_ptr+i) mod DEPTH]. It is combinational from storage and rd_ptr.
- Pop: rd_valid&&rd_ready advances rd_ptr by S (S=1 if mode_q[0]=1, else 2) and decrements count by S.
- Simultaneous push and pop: count_next = count + 1 − S.
- Underrun (count < LANES in STREAM): rd_valid=0, state stays STREAM.
- Reset mid-operation discards all contents.

## Timing
- Reset values:
  - state IDLE
  - wr_ptr=rd_ptr=count=0
  - rd_valid=0, wr_ready=1, rd_data=0 (storage cleared), state_o=0
- Push-to-count latency: 1 cycle.
- First window of a frame:
  - With ≥LANES words present at in_en rise in cutting mode: rd_valid at cycle +2 (FILL edge, then STREAM edge).
  - First-input mode: window appears 1 cycle after count reaches LANES.
- Pop takes effect at the accepting edge. The next window is visible the following cycle, with no bubble while count ≥ LANES.
- in_en deassertion drops rd_valid combinationally in the same cycle. No pop occurs on that cycle.
- Stride-2 pop with count==LANES leaves count=LANES−2. This is legal because LANES ≥ 2.

## Configuration
- INPREF_STATS_EN defined:
  - Adds output `underrun_cnt` (16 bits), saturating at 16'hFFFF.
  - Increments each cycle with state==STREAM && in_en && count<LANES.
  - Cleared by reset and at each IDLE→FILL transition.
- INPREF_STATS_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `inpref_pkg`:
  - State enum: IDLE/FILL/STREAM.
  - Mode constants: MODE_FIRST_S2=2'b00, MODE_FIRST_S1=2'b01, MODE_CUT_S2=2'b10, MODE_CUT_S1=2'b11.
  - Helper function stride_of(mode).
- One sub-module: `inpref_ring`, holding the circular storage, pointers, count and window read mux. The FSM, mode latch and stats logic stay in the top level.

## Test plan
- Reset: assert fsm_rst_n=0 mid-stream with count=6 → state_o=0, rd_valid=0, wr_ready=1. After release, rd_valid stays 0 until in_en is raised and 4 pushes are made.
- First input, stride 1 (mode 01): raise in_en, push 0..7, rd_ready=1 → windows {0,1,2,3}, {1,2,3,4} … {4,5,6,7}, exactly 5 windows; then rd_valid=0, count=3.
- First input, stride 2 (mode 00): push 0..7 → windows {0..3}, {2..5}, {4..7}, then rd_valid=0, count=2 (residue 6,7).
- Cutting (mode 11, en_cutting=1) following the previous frame: push 8,9 → first window {6,7,8,9}. Same stimulus with en_cutting=0 → residue is flushed and the first window is {8,9,x,x} only after 2 more pushes.
- Full: rd_ready=0, push 16 words → wr_ready=0 at count=16, 17th push is dropped. One pop at stride 2 → count=14, wr_ready=1.
- Stats (INPREF_STATS_EN): enter STREAM with count=4, pop once at stride 1, hold 5 cycles with no push → underrun_cnt=5; next frame start → 0.
